// File: rtl/regfile_mp_sb_pkg.sv
// regfile_mp_sb_pkg: shared constants for the register file and its scoreboard
//   ZeroWord    value returned for x0, disabled reads and during reset
//   RegAddrx0   address of the hard-wired zero register
//   WriteEnable active level of we_i bits
//   ReadEnable  active level of re_i bits
package regfile_mp_sb_pkg;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [4:0]  RegAddrx0   = 5'd0;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        ReadEnable  = 1'b1;
endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// regfile_mp_sb_scoreboard: write-pending busy vector with popcount
//   clk, rst      clock, synchronous active-high reset
//   issue_i       set busy for issue_addr_i (ignored for x0)
//   issue_addr_i  destination being issued
//   flush_i       clear every busy bit, overrides issue and writeback
//   clr_i         per-register writeback clear, entries 1..DEPTH-1
//   busy_o        registered busy vector, bit 0 always 0
//   busy_cnt_o    number of busy registers, forced to 0 while rst is high
module regfile_mp_sb_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_i,
    input  logic [ADDR_W-1:0]    issue_addr_i,
    input  logic                 flush_i,
    input  logic [2**ADDR_W-1:1] clr_i,
    output logic [2**ADDR_W-1:0] busy_o,
    output logic [ADDR_W:0]      busy_cnt_o
);
    import regfile_mp_sb_pkg::*;

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt;

    // issue beats a same-cycle writeback so a new producer is never lost
    always_comb begin
        busy_d = '0;
        for (int i = 1; i < DEPTH; i++)
            busy_d[i] = flush_i ? 1'b0 :
                        (issue_i && issue_addr_i == ADDR_W'(i)) ? 1'b1 :
                        clr_i[i] ? 1'b0 : busy_q[i];
    end

    always_ff @(posedge clk)
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;

    always_comb begin
        cnt = '0;
        for (int i = 1; i < DEPTH; i++)
            cnt = cnt + (ADDR_W+1)'(busy_q[i]);
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = rst ? '0 : cnt;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write bypass and busy scoreboard
//   clk, rst      clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i  NUM_WR write ports, port w at [w*W +: W]
//   re_i/raddr_i  NUM_RD read ports
//   rdata_o       combinational read data, bypassed from same-cycle writes
//   rbusy_o       source has an outstanding producer
//   issue_i/issue_addr_i  mark destination pending
//   flush_i       clear all busy bits
//   busy_cnt_o    number of busy registers
module regfile_mp_sb #(
    parameter int               DATA_W  = 32,
    parameter int               ADDR_W  = 5,
    parameter int               NUM_RD  = 2,
    parameter int               NUM_WR  = 1,
    parameter int               SP_IDX  = 2,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000fff0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we_i,
    input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
    input  logic [NUM_WR*DATA_W-1:0] wdata_i,
    input  logic [NUM_RD-1:0]        re_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    output logic [NUM_RD-1:0]        rbusy_o,
    input  logic                     issue_i,
    input  logic [ADDR_W-1:0]        issue_addr_i,
    input  logic                     flush_i,
    output logic [ADDR_W:0]          busy_cnt_o
);
    import regfile_mp_sb_pkg::*;

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:1]  clr;

    // port order gives the higher write port the last word on a shared address
    always_ff @(posedge clk)
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (i == SP_IDX) ? SP_INIT : DATA_W'(ZeroWord);
        end else begin
            for (int w = 0; w < NUM_WR; w++)
                if (we_i[w] == WriteEnable && waddr_i[w*ADDR_W +: ADDR_W] != ADDR_W'(RegAddrx0))
                    regs[waddr_i[w*ADDR_W +: ADDR_W]] <= wdata_i[w*DATA_W +: DATA_W];
        end

    always_comb begin
        clr = '0;
        for (int i = 1; i < DEPTH; i++)
            for (int w = 0; w < NUM_WR; w++)
                clr[i] = clr[i] | (we_i[w] == WriteEnable && waddr_i[w*ADDR_W +: ADDR_W] == ADDR_W'(i));
    end

    regfile_mp_sb_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .issue_i      (issue_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .clr_i        (clr),
        .busy_o       (busy),
        .busy_cnt_o   (busy_cnt_o)
    );

    genvar r;
    for (r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        logic [DATA_W-1:0] byp;
        logic              off;
        assign a   = raddr_i[r*ADDR_W +: ADDR_W];
        assign off = rst || re_i[r] != ReadEnable || a == ADDR_W'(RegAddrx0);
        always_comb begin
            hit = 1'b0;
            byp = DATA_W'(ZeroWord);
            for (int w = 0; w < NUM_WR; w++)
                if (we_i[w] == WriteEnable && waddr_i[w*ADDR_W +: ADDR_W] == a) begin
                    hit = 1'b1;
                    byp = wdata_i[w*DATA_W +: DATA_W];
                end
        end
        // a writeback landing this cycle resolves the hazard, so no stall
        assign rdata_o[r*DATA_W +: DATA_W] = off ? DATA_W'(ZeroWord) : hit ? byp : regs[a];
        assign rbusy_o[r] = !off && busy[a] && !hit;
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed and random checks of regfile_mp_sb against an array model
module tb_regfile_mp_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        issue;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [5:0]  cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    regfile_mp_sb #(.NUM_WR(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .we_i         (we),
        .waddr_i      (waddr),
        .wdata_i      (wdata),
        .re_i         (re),
        .raddr_i      (raddr),
        .rdata_o      (rdata),
        .rbusy_o      (rbusy),
        .issue_i      (issue),
        .issue_addr_i (issue_addr),
        .flush_i      (flush),
        .busy_cnt_o   (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = (i == 2) ? 32'h0000fff0 : 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_check();
        for (int p = 0; p < 2; p++) begin
            logic [4:0]  a;
            logic [31:0] ed;
            bit          hit, eb;
            a   = raddr[p*5 +: 5];
            hit = 1'b0;
            ed  = m_regs[a];
            for (int w = 0; w < 2; w++)
                if (we[w] && waddr[w*5 +: 5] == a) begin
                    hit = 1'b1;
                    ed  = wdata[w*32 +: 32];
                end
            if (rst || !re[p] || a == 5'd0) ed = 32'h0;
            eb = !rst && re[p] && a != 5'd0 && m_busy[a] && !hit;
            chk($sformatf("rdata%0d", p), rdata[p*32 +: 32], ed);
            chk($sformatf("rbusy%0d", p), {31'h0, rbusy[p]}, {31'h0, eb});
        end
        begin
            int n;
            n = 0;
            for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
            chk("busy_cnt", {26'h0, cnt}, rst ? 32'h0 : n);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
            return;
        end
        for (int w = 0; w < 2; w++)
            if (we[w]) begin
                if (waddr[w*5 +: 5] != 5'd0) m_regs[waddr[w*5 +: 5]] = wdata[w*32 +: 32];
                m_busy[waddr[w*5 +: 5]] = 1'b0;
            end
        if (issue && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
        if (flush)
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        we = 2'b00; issue = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1; we = 2'b00; waddr = '0; wdata = '0; issue = 1'b0;
        issue_addr = '0; flush = 1'b0; re = 2'b11; raddr = {5'd5, 5'd2};
        settle();
        chk("rst_rdata0", rdata[31:0], 32'h0);
        chk("rst_cnt", {26'h0, cnt}, 32'h0);
        tick();
        idle();
        settle();
        chk("sp_init", rdata[31:0], 32'h0000fff0);
        chk("x5_zero", rdata[63:32], 32'h0);
        tick();
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
        settle();
        chk("bypass_x5", rdata[63:32], 32'hDEADBEEF);
        tick();
        idle();
        settle();
        chk("array_x5", rdata[63:32], 32'hDEADBEEF);
        tick();
        we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h1234};
        raddr = {5'd7, 5'd0}; issue = 1'b1; issue_addr = 5'd0;
        settle();
        chk("x0_bypass", rdata[31:0], 32'h0);
        tick();
        idle();
        settle();
        chk("x0_read", rdata[31:0], 32'h0);
        chk("x0_issue_cnt", {26'h0, cnt}, 32'h0);
        tick();
        issue = 1'b1; issue_addr = 5'd7;
        settle();
        chk("x7_busy_N", {31'h0, rbusy[1]}, 32'h0);
        tick();
        idle();
        settle();
        chk("x7_busy_N1", {31'h0, rbusy[1]}, 32'h1);
        chk("x7_cnt_N1", {26'h0, cnt}, 32'h1);
        tick();
        settle();
        tick();
        we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'h77};
        settle();
        chk("x7_wb_busy", {31'h0, rbusy[1]}, 32'h0);
        chk("x7_wb_data", rdata[63:32], 32'h77);
        tick();
        idle();
        settle();
        chk("x7_cnt_N4", {26'h0, cnt}, 32'h0);
        tick();
        issue = 1'b1; issue_addr = 5'd7;
        we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'h99};
        settle();
        tick();
        idle();
        settle();
        chk("iss_wb_data", rdata[63:32], 32'h99);
        chk("iss_wb_busy", {31'h0, rbusy[1]}, 32'h1);
        tick();
        flush = 1'b1; issue = 1'b1; issue_addr = 5'd9;
        settle();
        tick();
        idle();
        settle();
        chk("flush_cnt", {26'h0, cnt}, 32'h0);
        tick();
        we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'hB, 32'hA}; raddr = {5'd3, 5'd3};
        settle();
        chk("dual_bypass", rdata[31:0], 32'hB);
        tick();
        idle();
        settle();
        chk("dual_array", rdata[63:32], 32'hB);
        tick();
        issue = 1'b1; issue_addr = 5'd4;
        settle();
        tick();
        issue_addr = 5'd6;
        settle();
        tick();
        idle();
        settle();
        chk("two_busy", {26'h0, cnt}, 32'h2);
        tick();
        rst = 1'b1; raddr = {5'd2, 5'd4};
        settle();
        chk("rst_mid_cnt", {26'h0, cnt}, 32'h0);
        chk("rst_mid_busy", {30'h0, rbusy}, 32'h0);
        tick();
        idle();
        raddr = {5'd3, 5'd2};
        settle();
        chk("post_rst_sp", rdata[31:0], 32'h0000fff0);
        chk("post_rst_x3", rdata[63:32], 32'h0);
        chk("post_rst_cnt", {26'h0, cnt}, 32'h0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(63) == 0);
            flush      = ($urandom_range(31) == 0);
            issue      = ($urandom_range(2) == 0);
            issue_addr = 5'($urandom_range(c % 3 == 0 ? 7 : 31));
            we         = 2'($urandom);
            waddr      = {5'($urandom_range(7)), 5'($urandom_range(31))};
            wdata      = {$urandom, $urandom};
            re         = 2'($urandom_range(3));
            raddr      = {5'($urandom_range(7)), 5'($urandom_range(31))};
            settle();
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
